// File: rtl/seq_pattern_detector.sv
// Serial KMP-style pattern detector: consumes qualified bits, pulses MATCH on
// pattern completion, keeps a saturating match count and a shift history.
module seq_pattern_detector #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic                       CLK,
  input  logic                       R,
  input  logic                       EN,
  input  logic                       D,
  input  logic                       CLR,
  output logic                       MATCH,
  output logic [$clog2(N+1)-1:0]     STATE,
  output logic [CNT_W-1:0]           COUNT,
  output logic [N-1:0]               HIST
);

  localparam int SW = $clog2(N+1);

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pbit(input int i);
    logic [N-1:0] tmp;
    tmp = PATTERN >> (N - 1 - i);
    return tmp[0];
  endfunction

  // Longest pattern prefix that is a suffix of (matched prefix of length s, then b).
  function automatic int kmp_next(input int s, input logic b);
    int   best;
    int   x;
    logic ok;
    logic c;
    best = 0;
    for (int k = 1; k <= s + 1; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        x = s + 1 - k + j;
        c = (x < s) ? pbit(x) : b;
        if (c != pbit(j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic int border_len();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < N; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pbit(j) != pbit(N - k + j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam int             BORDER   = border_len();
  localparam logic [SW-1:0]  BORDER_S = SW'(BORDER);
  localparam logic [SW-1:0]  LAST_S   = SW'(N - 1);

  // Transition tables, padded to a power of two so any state code indexes safely.
  logic [SW-1:0] nxt0 [2**SW];
  logic [SW-1:0] nxt1 [2**SW];

  for (genvar s = 0; s < 2**SW; s++) begin : g_tbl
    if (s < N) begin : g_live
      localparam int T0 = kmp_next(s, 1'b0);
      localparam int T1 = kmp_next(s, 1'b1);
      assign nxt0[s] = T0[SW-1:0];
      assign nxt1[s] = T1[SW-1:0];
    end else begin : g_pad
      assign nxt0[s] = '0;
      assign nxt1[s] = '0;
    end
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     hist_q,  hist_d;
  logic             match_q, match_d;
  logic             complete;

  assign complete = (state_q == LAST_S) && (D == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hist_d  = hist_q;
    match_d = 1'b0;
    if (CLR) begin
      state_d = '0;
      count_d = '0;
      hist_d  = '0;
    end else if (EN) begin
      hist_d = {hist_q[N-2:0], D};
      if (complete) begin
        match_d = 1'b1;
        if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
        state_d = OVERLAP ? BORDER_S : '0;
      end else begin
        state_d = D ? nxt1[state_q] : nxt0[state_q];
      end
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= '0;
      count_q <= '0;
      hist_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hist_q  <= hist_d;
      match_q <= match_d;
    end
  end

  assign MATCH = match_q;
  assign STATE = state_q;
  assign COUNT = count_q;
  assign HIST  = hist_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three configurations driven in parallel and
// compared against a stream-based reference model.
module tb_seq_pattern_detector;

  localparam int N = 4;

  logic CLK = 1'b0;
  logic R   = 1'b0;
  logic EN  = 1'b0;
  logic D   = 1'b0;
  logic CLR = 1'b0;

  logic       match0, match1, match2;
  logic [2:0] state0, state1, state2;
  logic [7:0] count0, count1;
  logic [1:0] count2;
  logic [3:0] hist0, hist1, hist2;

  always #5 CLK = ~CLK;

  seq_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .CLK(CLK), .R(R), .EN(EN), .D(D), .CLR(CLR),
    .MATCH(match0), .STATE(state0), .COUNT(count0), .HIST(hist0));

  seq_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .CLK(CLK), .R(R), .EN(EN), .D(D), .CLR(CLR),
    .MATCH(match1), .STATE(state1), .COUNT(count1), .HIST(hist1));

  seq_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c2 (
    .CLK(CLK), .R(R), .EN(EN), .D(D), .CLR(CLR),
    .MATCH(match2), .STATE(state2), .COUNT(count2), .HIST(hist2));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted-bit streams, with arrival-order pattern.
  bit pat_q[$] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit str_ov[$];
  bit str_no[$];
  int m_cnt_ov, m_cnt_no, m_cnt_c2;
  bit m_match_ov, m_match_no;
  logic [3:0] m_hist;

  function automatic bit ends_with_pattern(input bit q[$]);
    if (q.size() < N) return 1'b0;
    for (int j = 0; j < N; j++)
      if (q[q.size() - N + j] != pat_q[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_state(input bit q[$]);
    int best = 0;
    bit ok;
    for (int k = 1; k < N; k++) begin
      if (k <= q.size()) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (q[q.size() - k + j] != pat_q[j]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    str_ov.delete();
    str_no.delete();
    m_cnt_ov = 0; m_cnt_no = 0; m_cnt_c2 = 0;
    m_match_ov = 1'b0; m_match_no = 1'b0;
    m_hist = 4'b0;
  endtask

  task automatic model_edge(input logic en, input logic d, input logic clr);
    if (clr) begin
      model_reset();
    end else if (en) begin
      m_hist = {m_hist[2:0], d};
      str_ov.push_back(d);
      str_no.push_back(d);
      m_match_ov = ends_with_pattern(str_ov);
      if (m_match_ov) begin
        if (m_cnt_ov < 255) m_cnt_ov++;
        if (m_cnt_c2 < 3) m_cnt_c2++;
      end
      while (str_ov.size() > N) void'(str_ov.pop_front());
      m_match_no = ends_with_pattern(str_no);
      if (m_match_no) begin
        if (m_cnt_no < 255) m_cnt_no++;
        str_no.delete();
      end
      while (str_no.size() > N) void'(str_no.pop_front());
    end else begin
      m_match_ov = 1'b0;
      m_match_no = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ov.state", 32'(state0), 32'(model_state(str_ov)));
    chk("ov.match", 32'(match0), 32'(m_match_ov));
    chk("ov.count", 32'(count0), 32'(m_cnt_ov));
    chk("ov.hist",  32'(hist0),  32'(m_hist));
    chk("no.state", 32'(state1), 32'(model_state(str_no)));
    chk("no.match", 32'(match1), 32'(m_match_no));
    chk("no.count", 32'(count1), 32'(m_cnt_no));
    chk("no.hist",  32'(hist1),  32'(m_hist));
    chk("c2.count", 32'(count2), 32'(m_cnt_c2));
    chk("c2.match", 32'(match2), 32'(m_match_ov));
    chk("c2.state", 32'(state2), 32'(model_state(str_ov)));
  endtask

  task automatic step(input logic en, input logic d, input logic clr);
    @(negedge CLK);
    EN = en; D = d; CLR = clr;
    @(posedge CLK);
    #1;
    model_edge(en, d, clr);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".state"}, 32'(state0), 32'd0);
    chk({tag, ".match"}, 32'(match0), 32'd0);
    chk({tag, ".count"}, 32'(count0), 32'd0);
    chk({tag, ".hist"},  32'(hist0),  32'd0);
    chk({tag, ".c2cnt"}, 32'(count2), 32'd0);
    chk({tag, ".nostate"}, 32'(state1), 32'd0);
  endtask

  logic [0:6] seq1   = 7'b1011011;
  int         exp_ov [7] = '{1, 2, 3, 1, 2, 3, 1};
  int         exp_no [7] = '{1, 2, 3, 0, 0, 1, 1};
  int         exp_mt [7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    model_reset();
    // Reset held from time zero
    #2;
    check_zero("por");
    @(negedge CLK);
    R = 1'b1;

    // Overlapping and non-overlapping detection on the same stream
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq1[i], 1'b0);
      chk("t1.state_tbl", 32'(state0), 32'(exp_ov[i]));
      chk("t1.match_tbl", 32'(match0), 32'(exp_mt[i]));
      chk("t2.state_tbl", 32'(state1), 32'(exp_no[i]));
    end
    chk("t1.count_end", 32'(count0), 32'd2);
    chk("t1.hist_end",  32'(hist0),  32'hB);
    chk("t2.count_end", 32'(count1), 32'd1);

    // CLR with EN=1 after building STATE=3, COUNT=2
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6.state_pre", 32'(state0), 32'd3);
    chk("t6.count_pre", 32'(count0), 32'd2);
    step(1'b1, 1'b1, 1'b1);
    check_zero("t6.clr");
    step(1'b0, 1'b0, 1'b0);
    check_zero("t6.after");

    // EN gaps do not break a partial match
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i), 1'b0);
      chk("t3.hold_state", 32'(state0), 32'd3);
      chk("t3.hold_match", 32'(match0), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("t3.match", 32'(match0), 32'd1);
    chk("t3.count", 32'(count0), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("t3.match_fall", 32'(match0), 32'd0);

    // Counter saturation on the CNT_W=2 instance
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4.c2_first", 32'(count2), 32'd1);
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("t4.c2_match", 32'(match2), 32'd1);
      chk("t4.c2_count", 32'(count2), (r < 2) ? 32'(r + 2) : 32'd3);
    end
    chk("t4.ov_count", 32'(count0), 32'd5);

    // Asynchronous reset mid-pattern
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    #2;
    R = 1'b0;
    #1;
    model_reset();
    check_zero("t5.async");
    @(posedge CLK);
    #2;
    check_zero("t5.held");
    R = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("t5.state", 32'(state0), 32'd1);
    chk("t5.match", 32'(match0), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           1'($urandom),
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
